// File: rtl/cache_mem_arbiter.sv
// Arbiter sharing one burst memory port between icache and dcache.
// Dcache has priority, bounded by a streak limit so instruction fetch cannot starve.
module cache_mem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;

  logic d_req;
  logic d_blocked;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STREAK_MAX) ? STREAK_MAX : v + 4'd1;
  endfunction

  assign d_req     = d_pmem_read | d_pmem_write;
  // Dcache yields only when fetch is waiting and has already been passed over MAX_D_STREAK times.
  assign d_blocked = i_pmem_read & (streak_q == STREAK_MAX);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        if (d_req && !d_blocked) begin
          state_d  = D_XFER;
          addr_d   = d_pmem_address;
          wdata_d  = d_pmem_wdata;
          wr_d     = d_pmem_write;
          streak_d = i_pmem_read ? sat_inc(streak_q) : 4'd0;
        end else if (i_pmem_read) begin
          state_d  = I_XFER;
          addr_d   = i_pmem_address;
          wr_d     = 1'b0;
          streak_d = 4'd0;
        end
      end
      I_XFER, D_XFER: begin
        if (pmem_resp) state_d = DONE;
      end
      // One dead cycle so the cache can drop its request before arbitration resumes.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
    end
  end

  assign pmem_read    = (state_q == I_XFER) | ((state_q == D_XFER) & ~wr_q);
  assign pmem_write   = (state_q == D_XFER) & wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == I_XFER) & pmem_resp;
  assign d_pmem_resp  = (state_q == D_XFER) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  assign arb_busy     = (state_q != IDLE);
  assign grant_d      = (state_q == D_XFER);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_cache_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int MAX_D  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              arb_busy;
  logic              grant_d;

  int nvec = 0;
  int nerr = 0;

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_D_STREAK(MAX_D)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .arb_busy(arb_busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    i_pmem_read = 1; i_pmem_address = 32'h1234_5660;
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'hDEAD_BEE0; d_pmem_wdata = rand_line();
    pmem_resp = 1; pmem_rdata = rand_line();
    tick();
    tick();
    nvec++;
    if ({pmem_read, pmem_write, arb_busy, grant_d, i_pmem_resp, d_pmem_resp} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctl got=%b exp=000000",
               {pmem_read, pmem_write, arb_busy, grant_d, i_pmem_resp, d_pmem_resp});
    end
    nvec++;
    if (pmem_address !== '0) begin
      nerr++; $display("FAIL reset_addr got=%h exp=0", pmem_address);
    end
    nvec++;
    if (pmem_wdata !== '0) begin
      nerr++; $display("FAIL reset_wdata got=%h exp=0", pmem_wdata);
    end
    apply_reset();
  endtask

  task automatic test_i_only();
    logic [LINE_W-1:0] rd;
    apply_reset();
    i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    #1;
    nvec++;
    if ({pmem_read, arb_busy} !== 2'b00) begin
      nerr++; $display("FAIL i_only_pre got=%b exp=00", {pmem_read, arb_busy});
    end
    tick();
    nvec++;
    if ({pmem_read, pmem_write, arb_busy, grant_d} !== 4'b1010) begin
      nerr++; $display("FAIL i_only_grant got=%b exp=1010", {pmem_read, pmem_write, arb_busy, grant_d});
    end
    nvec++;
    if (pmem_address !== 32'h0000_1000) begin
      nerr++; $display("FAIL i_only_addr got=%h exp=00001000", pmem_address);
    end
    repeat (4) tick();
    nvec++;
    if ({pmem_read, i_pmem_resp} !== 2'b10) begin
      nerr++; $display("FAIL i_only_hold got=%b exp=10", {pmem_read, i_pmem_resp});
    end
    rd = rand_line(); pmem_rdata = rd; pmem_resp = 1;
    #1;
    nvec++;
    if ({pmem_read, i_pmem_resp, d_pmem_resp} !== 3'b110) begin
      nerr++; $display("FAIL i_only_resp got=%b exp=110", {pmem_read, i_pmem_resp, d_pmem_resp});
    end
    nvec++;
    if (i_pmem_rdata !== rd) begin
      nerr++; $display("FAIL i_only_rdata got=%h exp=%h", i_pmem_rdata, rd);
    end
    tick();
    i_pmem_read = 0;
    #1;
    nvec++;
    if ({pmem_read, arb_busy, i_pmem_resp} !== 3'b010) begin
      nerr++; $display("FAIL i_only_done got=%b exp=010", {pmem_read, arb_busy, i_pmem_resp});
    end
    pmem_resp = 0;
    tick();
    nvec++;
    if (arb_busy !== 1'b0) begin
      nerr++; $display("FAIL i_only_idle got=%b exp=0", arb_busy);
    end
  endtask

  task automatic test_d_write();
    logic [LINE_W-1:0] wd;
    wd = {32{8'hA5}};
    apply_reset();
    d_pmem_write = 1; d_pmem_address = 32'h8000_0020; d_pmem_wdata = wd;
    tick();
    nvec++;
    if ({pmem_read, pmem_write, arb_busy, grant_d} !== 4'b0111) begin
      nerr++; $display("FAIL d_wr_grant got=%b exp=0111", {pmem_read, pmem_write, arb_busy, grant_d});
    end
    d_pmem_wdata = rand_line();
    tick();
    nvec++;
    if (pmem_address !== 32'h8000_0020) begin
      nerr++; $display("FAIL d_wr_addr got=%h exp=80000020", pmem_address);
    end
    nvec++;
    if (pmem_wdata !== wd) begin
      nerr++; $display("FAIL d_wr_wdata got=%h exp=%h", pmem_wdata, wd);
    end
    pmem_resp = 1;
    #1;
    nvec++;
    if ({pmem_write, i_pmem_resp, d_pmem_resp} !== 3'b101) begin
      nerr++; $display("FAIL d_wr_resp got=%b exp=101", {pmem_write, i_pmem_resp, d_pmem_resp});
    end
    tick();
    pmem_resp = 0; d_pmem_write = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    i_pmem_read = 1; i_pmem_address = 32'h0000_2000;
    d_pmem_read = 1; d_pmem_address = 32'h0000_3000;
    tick();
    nvec++;
    if ({pmem_read, pmem_write, grant_d, pmem_address} !== {3'b101, 32'h0000_3000}) begin
      nerr++; $display("FAIL simul_d_first got=%b/%h exp=101/00003000",
                       {pmem_read, pmem_write, grant_d}, pmem_address);
    end
    pmem_resp = 1;
    #1;
    nvec++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b01) begin
      nerr++; $display("FAIL simul_d_resp got=%b exp=01", {i_pmem_resp, d_pmem_resp});
    end
    tick();
    pmem_resp = 0; d_pmem_read = 0;
    #1;
    nvec++;
    if ({pmem_read, arb_busy, grant_d} !== 3'b010) begin
      nerr++; $display("FAIL simul_done got=%b exp=010", {pmem_read, arb_busy, grant_d});
    end
    tick();
    tick();
    nvec++;
    if ({pmem_read, grant_d, pmem_address} !== {2'b10, 32'h0000_2000}) begin
      nerr++; $display("FAIL simul_i_next got=%b/%h exp=10/00002000", {pmem_read, grant_d}, pmem_address);
    end
    pmem_resp = 1;
    #1;
    nvec++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin
      nerr++; $display("FAIL simul_i_resp got=%b exp=10", {i_pmem_resp, d_pmem_resp});
    end
    tick();
    pmem_resp = 0; i_pmem_read = 0;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_g [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    i_pmem_read = 1; i_pmem_address = 32'h0000_4000;
    d_pmem_read = 1; d_pmem_address = 32'h0000_5000;
    for (int k = 0; k < 6; k++) begin
      tick();
      nvec++;
      if ({arb_busy, grant_d} !== {1'b1, exp_g[k]}) begin
        nerr++; $display("FAIL starve_grant%0d got=%b exp=%b", k, {arb_busy, grant_d}, {1'b1, exp_g[k]});
      end
      pmem_resp = 1;
      tick();
      pmem_resp = 0;
      tick();
    end
    i_pmem_read = 0; d_pmem_read = 0;
    tick();
  endtask

  task automatic test_addr_change();
    logic [LINE_W-1:0] w1;
    w1 = rand_line();
    apply_reset();
    d_pmem_read = 1; d_pmem_address = 32'h0000_0100; d_pmem_wdata = w1;
    tick();
    d_pmem_address = 32'h0000_0200; d_pmem_wdata = ~w1; d_pmem_write = 1;
    tick();
    tick();
    nvec++;
    if ({pmem_read, pmem_write, pmem_address} !== {2'b10, 32'h0000_0100}) begin
      nerr++; $display("FAIL addr_hold got=%b/%h exp=10/00000100", {pmem_read, pmem_write}, pmem_address);
    end
    nvec++;
    if (pmem_wdata !== w1) begin
      nerr++; $display("FAIL wdata_hold got=%h exp=%h", pmem_wdata, w1);
    end
    pmem_resp = 1;
    tick();
    pmem_resp = 0;
    #1;
    nvec++;
    if ({arb_busy, pmem_address} !== {1'b1, 32'h0000_0100}) begin
      nerr++; $display("FAIL addr_done got=%b/%h exp=1/00000100", arb_busy, pmem_address);
    end
    d_pmem_read = 0; d_pmem_write = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] wd;
    wd = rand_line();
    apply_reset();
    d_pmem_write = 1; d_pmem_address = 32'h0000_4440; d_pmem_wdata = wd;
    tick();
    tick();
    pmem_resp = 1; rst = 0;
    #1;
    nvec++;
    if ({pmem_read, pmem_write, arb_busy, grant_d, i_pmem_resp, d_pmem_resp} !== 6'b0) begin
      nerr++; $display("FAIL rst_mid_ctl got=%b exp=000000",
                       {pmem_read, pmem_write, arb_busy, grant_d, i_pmem_resp, d_pmem_resp});
    end
    nvec++;
    if ({pmem_address, pmem_wdata} !== '0) begin
      nerr++; $display("FAIL rst_mid_data got=%h/%h exp=0/0", pmem_address, pmem_wdata);
    end
    tick();
    pmem_resp = 0; rst = 1;
    tick();
    nvec++;
    if ({pmem_read, pmem_write, arb_busy, grant_d, pmem_address} !== {4'b0111, 32'h0000_4440}) begin
      nerr++; $display("FAIL rst_mid_regrant got=%b/%h exp=0111/00004440",
                       {pmem_read, pmem_write, arb_busy, grant_d}, pmem_address);
    end
    pmem_resp = 1;
    tick();
    pmem_resp = 0; d_pmem_write = 0;
    tick();
  endtask

  task automatic test_random();
    int                m_owner;  // 0 none, 1 icache, 2 dcache
    bit                m_done;
    int                m_streak;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    bit                m_wr;
    logic [5:0]        exp_ctl;
    logic [5:0]        got_ctl;
    bit                prev_i_resp;
    bit                prev_d_resp;
    int                op;
    apply_reset();
    m_owner = 0; m_done = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_wr = 0;
    prev_i_resp = 0; prev_d_resp = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_pmem_read && prev_i_resp) i_pmem_read = 0;
      else if (!i_pmem_read && $urandom_range(0, 3) == 0) i_pmem_read = 1;
      if ($urandom_range(0, 3) == 0) i_pmem_address = $urandom & 32'hFFFF_FFE0;
      if ((d_pmem_read || d_pmem_write) && prev_d_resp) begin
        d_pmem_read = 0; d_pmem_write = 0;
      end else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, 2);
        d_pmem_read = (op != 1); d_pmem_write = (op != 0);
      end
      if ($urandom_range(0, 3) == 0) d_pmem_address = $urandom & 32'hFFFF_FFE0;
      d_pmem_wdata = rand_line();
      pmem_rdata   = rand_line();
      pmem_resp    = ($urandom_range(0, 2) == 0);
      rst          = ($urandom_range(0, 199) != 0);
      if (!rst) begin
        m_owner = 0; m_done = 0; m_streak = 0; m_addr = '0; m_wdata = '0; m_wr = 0;
      end
      #1;
      exp_ctl = {(m_owner == 1) || (m_owner == 2 && !m_wr), (m_owner == 2 && m_wr),
                 (m_owner != 0) || m_done, (m_owner == 2),
                 (m_owner == 1) && pmem_resp, (m_owner == 2) && pmem_resp};
      got_ctl = {pmem_read, pmem_write, arb_busy, grant_d, i_pmem_resp, d_pmem_resp};
      nvec++;
      if (got_ctl !== exp_ctl) begin
        nerr++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, got_ctl, exp_ctl);
      end
      nvec++;
      if (pmem_address !== m_addr) begin
        nerr++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, pmem_address, m_addr);
      end
      nvec++;
      if (pmem_wdata !== m_wdata) begin
        nerr++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, pmem_wdata, m_wdata);
      end
      nvec++;
      if ({i_pmem_rdata, d_pmem_rdata} !== {pmem_rdata, pmem_rdata}) begin
        nerr++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, d_pmem_rdata, pmem_rdata);
      end
      prev_i_resp = i_pmem_resp;
      prev_d_resp = d_pmem_resp;
      if (rst) begin
        if (m_done) begin
          m_done = 0;
        end else if (m_owner != 0) begin
          if (pmem_resp) begin m_owner = 0; m_done = 1; end
        end else if ((d_pmem_read || d_pmem_write) && !(i_pmem_read && m_streak == MAX_D)) begin
          m_owner = 2; m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_wr = d_pmem_write;
          m_streak = i_pmem_read ? ((m_streak + 1 > MAX_D) ? MAX_D : m_streak + 1) : 0;
        end else if (i_pmem_read) begin
          m_owner = 1; m_addr = i_pmem_address; m_streak = 0;
        end
      end
      tick();
    end
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_simultaneous();
    test_starvation();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
